// File: rtl/fifo_fill_ctrl.sv
// Hysteresis write controller for a downstream FIFO: streams a constant or incrementing
// pattern while occupancy is low, pauses at a high watermark, resumes at a low watermark.
module fifo_fill_ctrl #(
    parameter int unsigned          DATA_W    = 8,
    parameter int unsigned          CNT_W     = 4,
    parameter int unsigned          HIGH_MARK = 5,
    parameter int unsigned          LOW_MARK  = 2,
    parameter logic [DATA_W-1:0]    INIT_VAL  = 8'hAA,
    parameter int unsigned          PAT_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CNT_W-1:0]  fifo_words,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic [DATA_W-1:0] fifo_data,
    output logic [1:0]        state_o,
    output logic [15:0]       wr_count
);

    if (!(LOW_MARK < HIGH_MARK && HIGH_MARK <= (1 << CNT_W) - 1)) begin : g_bad_marks
        $error("fifo_fill_ctrl: need LOW_MARK < HIGH_MARK <= 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] HighMarkW = CNT_W'(HIGH_MARK);
    localparam logic [CNT_W-1:0] LowMarkW  = CNT_W'(LOW_MARK);

    typedef enum logic [1:0] {
        StStop    = 2'b00,
        StWriting = 2'b01,
        StPaused  = 2'b10
    } state_e;

    // Plain vector so the unused 2'b11 encoding stays representable and recoverable.
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StStop;
            data_q  <= INIT_VAL;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // Next state: enable dominates, then the watermarks.
    always_comb begin
        state_d = StStop;
        if (enable) begin
            unique case (state_q)
                StStop:    state_d = StWriting;
                StWriting: state_d = (fifo_words >= HighMarkW) ? StPaused : StWriting;
                StPaused:  state_d = (fifo_words <= LowMarkW) ? StWriting : StPaused;
                default:   state_d = StStop;
            endcase
        end
    end

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (wr_en) begin
            count_d = count_q + 16'd1;
            if (PAT_MODE == 1) begin
                data_d = data_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_en     = (state_q == StWriting) && !fifo_full;
        fifo_data = data_q;
        state_o   = state_q;
        wr_count  = count_q;
    end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Bench for fifo_fill_ctrl: a constant-pattern and an incrementing-pattern instance share
// stimulus; both are compared against a behavioural model of the controller rules.
module tb_fifo_fill_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] fifo_words;
    logic       fifo_full;

    logic       wr_en_c, wr_en_i;
    logic [7:0] data_c, data_i;
    logic [1:0] state_c, state_i;
    logic [15:0] count_c, count_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state as 0 STOP / 1 WRITING / 2 PAUSED / 3 illegal.
    int m_state;
    int m_count;
    int m_inc;

    always #5 clk = ~clk;

    fifo_fill_ctrl #(
        .DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2), .INIT_VAL(8'hAA), .PAT_MODE(0)
    ) u_dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_words(fifo_words),
        .fifo_full(fifo_full), .wr_en(wr_en_c), .fifo_data(data_c), .state_o(state_c),
        .wr_count(count_c)
    );

    fifo_fill_ctrl #(
        .DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2), .INIT_VAL(8'hFE), .PAT_MODE(1)
    ) u_dut_i (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_words(fifo_words),
        .fifo_full(fifo_full), .wr_en(wr_en_i), .fifo_data(data_i), .state_o(state_i),
        .wr_count(count_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_count = 0;
        m_inc   = 8'hFE;
    endtask

    task automatic check_all(input string tag);
        logic exp_wr;
        exp_wr = (m_state == 1) && !fifo_full;
        chk({tag, ".state_c"}, {30'd0, state_c}, m_state);
        chk({tag, ".state_i"}, {30'd0, state_i}, m_state);
        chk({tag, ".wr_en_c"}, {31'd0, wr_en_c}, {31'd0, exp_wr});
        chk({tag, ".wr_en_i"}, {31'd0, wr_en_i}, {31'd0, exp_wr});
        chk({tag, ".data_c"}, {24'd0, data_c}, 32'hAA);
        chk({tag, ".data_i"}, {24'd0, data_i}, m_inc);
        chk({tag, ".count_c"}, {16'd0, count_c}, m_count);
        chk({tag, ".count_i"}, {16'd0, count_i}, m_count);
    endtask

    // Apply settled inputs, optionally check, then advance model and DUT one clock.
    task automatic cycle(input string tag, input bit do_check);
        int nxt;
        #1;
        if (do_check) check_all(tag);
        @(posedge clk);
        if ((m_state == 1) && !fifo_full) begin
            m_count = (m_count + 1) % 65536;
            m_inc   = (m_inc + 1) % 256;
        end
        if (!enable || m_state == 0 || m_state == 3) nxt = (enable && m_state == 0) ? 1 : 0;
        else if (m_state == 1) nxt = (fifo_words >= 5) ? 2 : 1;
        else nxt = (fifo_words <= 2) ? 1 : 2;
        m_state = nxt;
        #1;
    endtask

    initial begin
        int guard;
        rst_n      = 1'b0;
        enable     = 1'b0;
        fifo_words = 4'd0;
        fifo_full  = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Test 1 / 3: enable with drained FIFO; mode 1 walks FE, FF, 00, 01
        enable = 1'b1;
        for (int i = 0; i < 4; i++) cycle("run", 1'b1);

        // Stall on full for 4 cycles
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) cycle("full", 1'b1);
        fifo_full = 1'b0;

        // Test 2: fill without drain, then hysteresis band, then resume
        for (int w = 0; w <= 7; w++) begin
            fifo_words = 4'(w);
            cycle("fill", 1'b1);
        end
        fifo_words = 4'd3;
        for (int i = 0; i < 3; i++) cycle("band", 1'b1);
        fifo_words = 4'd2;
        for (int i = 0; i < 2; i++) cycle("resume", 1'b1);

        // Test 4: drop enable while PAUSED and while WRITING
        fifo_words = 4'd9;
        for (int i = 0; i < 2; i++) cycle("topause", 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) cycle("stop_p", 1'b1);
        enable = 1'b1;
        fifo_words = 4'd0;
        for (int i = 0; i < 3; i++) cycle("reen", 1'b1);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) cycle("stop_w", 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) cycle("reen2", 1'b1);

        // Test 5: asynchronous reset between edges mid-burst
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b1);

        // Randomised phase
        for (int i = 0; i < 400; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            fifo_words = 4'($urandom_range(0, 15));
            fifo_full  = ($urandom_range(0, 4) == 0);
            cycle("rand", 1'b1);
        end

        // Test 6: write counter wrap
        enable     = 1'b1;
        fifo_words = 4'd0;
        fifo_full  = 1'b0;
        cycle("prewrap", 1'b1);
        cycle("prewrap", 1'b1);
        guard = 0;
        while (m_count != 16'hFFFF && guard < 70000) begin
            cycle("wrap", 1'b0);
            guard++;
        end
        chk("wrap_bound", guard < 70000, 1);
        cycle("wrap_ffff", 1'b1);
        cycle("wrap_zero", 1'b1);

        // Illegal encoding recovers to STOP on the next clock
        force u_dut_c.state_q = 2'b11;
        force u_dut_i.state_q = 2'b11;
        #1;
        release u_dut_c.state_q;
        release u_dut_i.state_q;
        m_state = 3;
        cycle("illegal", 1'b1);
        cycle("recover", 1'b1);
        cycle("rerun", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
